// File: rtl/instr_prefetch.sv
// Instruction prefetch queue.
// Fetches sequential instructions from a combinational instruction memory
// into a small circular FIFO of {pc, instruction} entries. A redirect flushes
// the queue and restarts fetch at a new address. en=0 stops new fetches, but
// pops and redirects still take effect.
module instr_prefetch #(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   parameter int IW    = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   output logic [AW-1:0]            imem_addr,
   input  logic [IW-1:0]            imem_data,
   output logic                     instr_valid,
   output logic [IW-1:0]            instr,
   output logic [AW-1:0]            instr_pc,
   input  logic                     instr_ready,
   input  logic                     redirect,
   input  logic [AW-1:0]            redirect_addr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PC_ONE  = AW'(1);

   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [AW-1:0] fetch_pc_r;
   logic [AW-1:0] pc_mem_r  [DEPTH];
   logic [IW-1:0] ins_mem_r [DEPTH];
   logic          pop_s;
   logic          push_s;
   logic          valid_s;

   // Handshake decode: a redirect suppresses both push and pop in its cycle.
   always_comb begin
      valid_s = (count_r != {CW{1'b0}});
      pop_s   = valid_s && instr_ready && !redirect;
      push_s  = en && !redirect && ((count_r < DEPTH_C) || pop_s);
   end

   // Queue pointers, occupancy and fetch PC; reset and redirect both flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_r     <= {PW{1'b0}};
         tail_r     <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         fetch_pc_r <= {AW{1'b0}};
      end else if (redirect) begin
         head_r     <= {PW{1'b0}};
         tail_r     <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         fetch_pc_r <= redirect_addr;
      end else begin
         if (push_s) begin
            tail_r     <= tail_r + PTR_ONE;
            fetch_pc_r <= fetch_pc_r + PC_ONE;
         end
         if (pop_s) begin
            head_r <= head_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; stale contents are harmless because count gates the head.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[tail_r]  <= fetch_pc_r;
         ins_mem_r[tail_r] <= imem_data;
      end
   end

   // Head presentation, forced to zero while the queue is empty.
   always_comb begin
      instr_valid = valid_s;
      imem_addr   = fetch_pc_r;
      count       = count_r;
      if (valid_s) begin
         instr    = ins_mem_r[head_r];
         instr_pc = pc_mem_r[head_r];
      end else begin
         instr    = {IW{1'b0}};
         instr_pc = {AW{1'b0}};
      end
   end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, sets the prefetch queue entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter AW, default 8, sets the instruction address width.
REQ-003 Parameter IW, default 12, sets the instruction word width.
REQ-004 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit, is the reset: asynchronous and active-low.
REQ-006 Port en, input, 1 bit, is the fetch enable; 0 SHALL halt new fetches.
REQ-007 Port imem_addr, output, AW bits, is the instruction memory address (the fetch PC).
REQ-008 Port imem_data, input, IW bits, is the instruction memory read data, combinationally valid in the same cycle as imem_addr.
REQ-009 Port instr_valid, output, 1 bit, means the queue head is valid.
REQ-010 Port instr, output, IW bits, is the queue head instruction.
REQ-011 Port instr_pc, output, AW bits, is the address of the queue head instruction.
REQ-012 Port instr_ready, input, 1 bit, means the processor accepts the head.
REQ-013 Port redirect, input, 1 bit, requests a flush and a fetch restart (branch/jump).
REQ-014 Port redirect_addr, input, AW bits, is the restart address.
REQ-015 Port count, output, clog2(DEPTH)+1 bits, is the number of valid queue entries.

Function
REQ-016 The queue SHALL be a circular FIFO of DEPTH entries, each holding {pc, instruction}; head, tail and count SHALL be registers.
REQ-017 pop SHALL be instr_valid && instr_ready && !redirect.
REQ-018 push SHALL be en && !redirect && (count < DEPTH || pop).
- A push writes {fetch_pc, imem_data} at tail.
- A push increments fetch_pc by 1, modulo 2^AW (255 wraps to 0).
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when the queue is full or holds one entry.
REQ-020 instr_valid SHALL equal (count != 0).
REQ-021 instr and instr_pc SHALL be driven from the head entry; both SHALL be 0 when count == 0.
REQ-022 imem_addr SHALL equal fetch_pc at all times.
REQ-023 A redirect sampled at edge T SHALL, at that edge:
- clear head, tail and count;
- load fetch_pc with redirect_addr;
- perform no push;
- perform no pop. The presented head is discarded and is not a handshake.
REQ-024 After a redirect at edge T, the entry for redirect_addr SHALL be pushed at edge T+1, giving instr_valid=1 with instr_pc=redirect_addr after T+1 (when en=1).
REQ-025 With en=1 and instr_ready held at 1, throughput SHALL be one instruction per cycle, with one cycle of fetch-to-valid latency.
REQ-026 When en=0, no push SHALL occur and fetch_pc SHALL hold; pops and redirects SHALL still operate.
REQ-027 count SHALL never exceed DEPTH and never underflow; pop is impossible when count == 0.
REQ-028 instr and instr_pc SHALL remain stable while instr_valid=1 and instr_ready=0, unless redirect is asserted.

Reset
REQ-029 While rst=0, the block SHALL immediately (asynchronously) set fetch_pc=0, head=0, tail=0, count=0, instr_valid=0, instr=0, instr_pc=0 and imem_addr=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; no write to queue storage SHALL be required for correctness.
REQ-031 The first rising edge with rst=1 and en=1 SHALL push address 0.

Verification
REQ-032 Free run: release rst, en=1, instr_ready=1, ROM[i]=i+0x100.
- imem_addr SHALL be 0,1,2,... on successive cycles.
- instr_valid SHALL be 1 from the first edge.
- instr SHALL be 0x100, 0x101, ... one per cycle, with count=1.
REQ-033 Backpressure: instr_ready=0.
- After 4 edges: count=4, imem_addr=4, head instr_pc=0.
- SHALL hold unchanged thereafter.
- Raising instr_ready for one cycle SHALL pop pc 0 and push pc 4, with count staying 4.
REQ-034 Redirect while full: count=4, redirect=1, redirect_addr=0x80.
- After the edge: count=0, instr_valid=0, imem_addr=0x80.
- After the next edge: instr_valid=1, instr_pc=0x80.
REQ-035 Wrap-around: redirect to 0xFE with instr_ready=1; instr_pc sequence SHALL be 0xFE, 0xFF, 0x00, 0x01.
REQ-036 Reset mid-operation: with count=3 and imem_addr=0x23, drive rst=0 between edges.
- Outputs SHALL go to count=0, instr_valid=0, imem_addr=0 before the next edge.
- After release, fetch SHALL restart at address 0.
REQ-037 Halt: with count=2 and instr_ready=1, set en=0.
- Two pops SHALL occur, then count=0.
- imem_addr SHALL hold constant.
- Setting en=1 SHALL resume fetch from the held address.
